// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and width helper for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_LW   = 4'b1001;
    localparam logic [3:0] OP_SW   = 4'b1010;
    localparam logic [3:0] OP_LUI  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLL  = 4'b1101;
    localparam logic [3:0] OP_SRL  = 4'b1110;
    localparam logic [3:0] OP_SRA  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2, used for shift-amount and counter widths.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] prod_o
);

    localparam int unsigned ITER = W / MUL_BITS;
    localparam int unsigned CW   = clog2(ITER) + 1;

    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [W-1:0]  pp;
    logic [W-1:0]  sum;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;

    // Partial products for this step, next-state of the shift-add datapath.
    always_comb begin
        pp   = '0;
        a_sh = a_q;
        b_sh = b_q;
        for (int unsigned j = 0; j < MUL_BITS; j++) begin
            if (b_sh[0]) pp = pp + a_sh;
            a_sh = a_sh << 1;
            b_sh = b_sh >> 1;
        end
        sum    = acc_q + pp;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            a_d    = a_i;
            b_d    = b_i;
            acc_d  = '0;
            cnt_d  = CW'(ITER);
            busy_d = 1'b1;
        end else if (busy_q) begin
            a_d   = a_q << MUL_BITS;
            b_d   = b_q >> MUL_BITS;
            acc_d = sum;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Final step's sum is presented combinationally so the parent can register it at the same edge.
    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CW'(1));
    assign prod_o = sum;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle parametrised ALU with valid/ready handshakes on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned W        = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] src1_i,
    input  logic [W-1:0] src2_i,
    input  logic [3:0]   ALU_control_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] result_o,
    output logic         zero_o,
    output logic         overflow_o
);

    localparam int unsigned SHW = clog2(W);

    state_e         state_q, state_d;
    logic [W-1:0]   result_q, result_d;
    logic           zero_q, zero_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   alu_res;
    logic           alu_ovf;
    logic [W-1:0]   sum;
    logic [W-1:0]   diff;
    logic [SHW-1:0] shamt;
    logic           accept;
    logic           mul_start;
    logic           mul_busy;
    logic           mul_done;
    logic [W-1:0]   mul_prod;

    alu_mul_iter #(
        .W        (W),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .a_i     (src1_i),
        .b_i     (src2_i),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    assign ready_o = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    assign accept  = valid_i && ready_o;

    // Single-cycle operation mux; MUL goes through the iterative unit instead.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        sum     = src1_i + src2_i;
        diff    = src1_i - src2_i;
        shamt   = src2_i[SHW-1:0];
        case (ALU_control_i)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src1_i[W-1] == src2_i[W-1]) && (sum[W-1] != src1_i[W-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (src1_i[W-1] != src2_i[W-1]) && (diff[W-1] != src1_i[W-1]);
            end
            OP_OR:         alu_res = src1_i | src2_i;
            OP_AND:        alu_res = src1_i & src2_i;
            OP_NOR:        alu_res = ~(src1_i | src2_i);
            OP_SLTU:       alu_res = W'(src1_i < src2_i);
            OP_SLT:        alu_res = W'($signed(src1_i) < $signed(src2_i));
            OP_LW, OP_SW:  alu_res = src1_i + W'(src2_i[15:0]);
            OP_LUI:        alu_res = W'({src2_i[15:0], 16'h0000});
            OP_SLL:        alu_res = src1_i << shamt;
            OP_SRL:        alu_res = src1_i >> shamt;
            OP_SRA:        alu_res = $unsigned($signed(src1_i) >>> shamt);
            default:       alu_res = '0;
        endcase
    end

    // Handshake FSM: next state and output register updates.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        mul_start = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (ALU_control_i == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        state_d  = DONE;
                    end
                end else if ((state_q == DONE) && ready_i) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    result_d = mul_prod;
                    zero_d   = (mul_prod == '0);
                    ovf_d    = 1'b0;
                    state_d  = DONE;
                end else if (!mul_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign valid_o    = (state_q == DONE);
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised self-checking bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;

    localparam int W = 32;
    parameter int MUL_BITS = 1;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [3:0]  ALU_control_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mc #(.W(W), .MUL_BITS(MUL_BITS)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .src1_i        (src1_i),
        .src2_i        (src2_i),
        .ALU_control_i (ALU_control_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .result_o      (result_o),
        .zero_o        (zero_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v);
        longint      sa, sb, s;
        logic [63:0] p;
        int          sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b % 32);
        v  = 1'b0;
        r  = '0;
        case (op)
            4'd0: begin s = sa + sb; r = a + b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd6: begin s = sa - sb; r = a - b; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd1:  r = a | b;
            4'd2:  r = a & b;
            4'd3:  r = (a < b) ? 32'd1 : 32'd0;
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  begin p = 64'(a) * 64'(b); r = p[31:0]; end
            4'd9, 4'd10: r = a + (b % 65536);
            4'd11: r = (b % 65536) * 65536;
            4'd12: r = ~(a | b);
            4'd13: r = a << sh;
            4'd14: r = a >> sh;
            4'd15: begin s = sa >>> sh; r = s[31:0]; end
            default: r = '0;
        endcase
    endfunction

    // One full transaction with ready_i held high; checks latency and all outputs.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] got);
        logic [31:0] er;
        logic        ev;
        int          lat;
        int          busy_bad;
        int          exp_lat;
        model(op, a, b, er, ev);
        exp_lat = (op == 4'd8) ? (W / MUL_BITS + 1) : 1;
        @(negedge clk_i);
        valid_i = 1'b1; ALU_control_i = op; src1_i = a; src2_i = b; ready_i = 1'b1;
        #1;
        check({tag, "_ready"}, 64'(ready_o), 64'd1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        lat = 0;
        busy_bad = 0;
        do begin
            @(negedge clk_i);
            lat++;
            if (!valid_o && ready_o) busy_bad++;
        end while (!valid_o && lat < 100);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_ready"}, 64'(busy_bad), 64'd0);
        check({tag, "_result"}, 64'(result_o), 64'(er));
        check({tag, "_zero"}, 64'(zero_o), 64'(er == 32'd0));
        check({tag, "_ovf"}, 64'(overflow_o), 64'(ev));
        got = result_o;
        @(posedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [31:0] special [4];
        logic [31:0] a, b;
        logic [3:0]  op;
        int          bad;

        special[0] = 32'h0000_0000;
        special[1] = 32'h8000_0000;
        special[2] = 32'h7FFF_FFFF;
        special[3] = 32'hFFFF_FFFF;

        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        src1_i = '0; src2_i = '0; ALU_control_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        check("rst_zero", 64'(zero_o), 64'd1);
        check("rst_ovf", 64'(overflow_o), 64'd0);

        do_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, got);
        check("add_ovf_const", 64'(got), 64'h8000_0000);
        check("add_ovf_flag", 64'(overflow_o), 64'd1);
        do_op("sub_zero", 4'd6, 32'd5, 32'd5, got);
        check("sub_zero_const", 64'(got), 64'd0);
        do_op("slt", 4'd7, 32'h8000_0000, 32'h7FFF_FFFF, got);
        check("slt_const", 64'(got), 64'd1);
        do_op("sltu", 4'd3, 32'h8000_0000, 32'h7FFF_FFFF, got);
        check("sltu_const", 64'(got), 64'd0);
        do_op("mul", 4'd8, 32'h0000_FFFF, 32'h0001_0001, got);
        check("mul_const", 64'(got), 64'hFFFF_FFFF);
        do_op("sra", 4'd15, 32'h8000_0000, 32'd31, got);
        check("sra_const", 64'(got), 64'hFFFF_FFFF);
        do_op("srl", 4'd14, 32'h8000_0000, 32'd31, got);
        check("srl_const", 64'(got), 64'd1);
        do_op("sll32", 4'd13, 32'd1, 32'd32, got);
        check("sll32_const", 64'(got), 64'd1);
        do_op("lui", 4'd11, 32'hDEAD_BEEF, 32'h0000_1234, got);
        check("lui_const", 64'(got), 64'h1234_0000);
        do_op("op4", 4'd4, 32'h1234_5678, 32'h9ABC_DEF0, got);
        check("op4_const", 64'(got), 64'd0);
        do_op("op5", 4'd5, 32'hFFFF_FFFF, 32'h1, got);
        check("op5_const", 64'(got), 64'd0);

        // Back-pressure in DONE, then a back-to-back accept on release.
        @(negedge clk_i);
        valid_i = 1'b1; ALU_control_i = 4'd0; src1_i = 32'd3; src2_i = 32'd4; ready_i = 1'b0;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_valid", 64'(valid_o), 64'd1);
        check("bp_result", 64'(result_o), 64'd7);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== 32'd7 || zero_o !== 1'b0) bad++;
        end
        check("bp_hold", 64'(bad), 64'd0);
        ready_i = 1'b1; valid_i = 1'b1; ALU_control_i = 4'd2;
        src1_i = 32'h0000_F0F0; src2_i = 32'h0000_FF00;
        #1;
        check("b2b_ready", 64'(ready_o), 64'd1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        @(negedge clk_i);
        check("b2b_valid", 64'(valid_o), 64'd1);
        check("b2b_result", 64'(result_o), 64'h0000_F000);
        @(posedge clk_i);

        // Randomised operations against the model.
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            do_op("rand", op, a, b, got);
        end

        // Reset in the middle of a MUL must drop it without a result.
        @(negedge clk_i);
        valid_i = 1'b1; ALU_control_i = 4'd8; src1_i = 32'h1234_5678; src2_i = 32'h9ABC_DEF1; ready_i = 1'b1;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        repeat (10) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_ready", 64'(ready_o), 64'd1);
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_zero", 64'(zero_o), 64'd1);
        check("midrst_result", 64'(result_o), 64'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o !== 1'b0 || result_o !== 32'd0) bad++;
        end
        check("midrst_no_stale", 64'(bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
